// File: rtl/store64_stream.sv
// store64_stream: serializes 64-bit little-endian Keccak lanes into exactly i_len output bytes.
// Ports:
//   i_clk, i_rst                     clock and synchronous active-high reset
//   i_start, i_len                   request pulse and byte count, taken only in IDLE
//   i_lane_valid, i_lane, o_lane_ready   lane input handshake
//   o_byte_valid, o_byte, o_byte_last, i_byte_ready   byte output handshake
//   o_busy, o_done                   not-idle flag and one-cycle completion pulse
module store64_stream #(
    parameter int BW_DATA = 64,
    parameter int BW_BYTE = 8,
    parameter int BW_LEN  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [BW_LEN-1:0]  i_len,
    input  logic               i_lane_valid,
    input  logic [BW_DATA-1:0] i_lane,
    output logic               o_lane_ready,
    output logic               o_byte_valid,
    output logic [BW_BYTE-1:0] o_byte,
    output logic               o_byte_last,
    input  logic               i_byte_ready,
    output logic               o_busy,
    output logic               o_done
);
    typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;
    state_t             state_q, state_d;
    logic [BW_LEN-1:0]  rem_q, rem_d;
    logic [2:0]         idx_q, idx_d;
    logic [BW_DATA-1:0] shreg_q, shreg_d;
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        unique case (state_q)
            IDLE: if (i_start) begin
                state_d = (i_len == '0) ? DONE : LOAD;
                rem_d   = i_len;
            end
            LOAD: if (i_lane_valid) begin
                shreg_d = i_lane;
                idx_d   = 3'd0;
                state_d = EMIT;
            end
            // Finishing the request takes priority over fetching another lane,
            // so surplus bytes of a partial final lane are simply dropped.
            EMIT: if (i_byte_ready) begin
                shreg_d = shreg_q >> BW_BYTE;
                idx_d   = idx_q + 3'd1;
                rem_d   = rem_q - BW_LEN'(1);
                state_d = (rem_q == BW_LEN'(1)) ? DONE : (idx_q == 3'd7) ? LOAD : EMIT;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end
    assign o_lane_ready = state_q == LOAD;
    assign o_byte_valid = state_q == EMIT;
    assign o_byte       = (state_q == EMIT) ? shreg_q[BW_BYTE-1:0] : '0;
    assign o_byte_last  = (state_q == EMIT) && (rem_q == BW_LEN'(1));
    assign o_busy       = state_q != IDLE;
    assign o_done       = state_q == DONE;
endmodule

// File: tb/tb_store64_stream.sv
// tb_store64_stream: directed self-checking bench for store64_stream.
module tb_store64_stream;
    logic        clk = 0;
    logic        rst, start, lane_valid, byte_ready;
    logic [15:0] len;
    logic [63:0] lane;
    logic        lane_ready, byte_valid, byte_last, busy, done;
    logic [7:0]  byte_o;
    logic [63:0] lanes [4];
    int          total = 0, passed = 0;

    store64_stream dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len),
        .i_lane_valid(lane_valid), .i_lane(lane), .o_lane_ready(lane_ready),
        .o_byte_valid(byte_valid), .o_byte(byte_o), .o_byte_last(byte_last),
        .i_byte_ready(byte_ready), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else passed++;
    endtask

    // Runs one request with ready driven from pat (MSB first, one bit per EMIT cycle, then 1).
    task automatic run(input int n, input logic [7:0] base, input logic [9:0] pat,
                       input int exp_cyc, input bit poke);
        int cyc = 0, pi = 0, li = 0, nb = 0;
        logic [7:0] pb = 0, eb;
        logic pv = 0;
        start = 1; len = n[15:0]; step(); start = 0;
        while (!done && cyc < 100) begin
            if (pv) chk("stall_hold", {byte_valid, byte_o}, {1'b1, pb});
            lane_valid = lane_ready;
            lane = lanes[li[1:0]];
            byte_ready = byte_valid ? ((pi < 10) ? pat[9-pi] : 1'b1) : 1'b0;
            if (byte_valid) pi++;
            start = poke && cyc == 3;
            if (poke && cyc == 3) len = 16'd3;
            if (lane_ready) li++;
            if (byte_valid && byte_ready) begin
                eb = base + nb[7:0];
                chk("byte", {byte_last, byte_o}, {nb == n - 1, eb});
                nb++;
            end
            pv = byte_valid && !byte_ready;
            pb = byte_o;
            step();
            cyc++;
        end
        start = 0; lane_valid = 0; byte_ready = 0;
        chk("done_pulse", {done, byte_valid, lane_ready}, 3'b100);
        chk("cycles", cyc, exp_cyc);
        chk("byte_count", nb, n);
        chk("lane_count", li, (n + 7) / 8);
        step();
        chk("back_idle", {busy, done}, 2'b00);
    endtask

    initial begin
        rst = 1; start = 0; len = 0; lane_valid = 0; lane = 0; byte_ready = 0;
        lanes[0] = 64'h0807060504030201; lanes[1] = 0; lanes[2] = 0; lanes[3] = 0;
        step(); step();
        rst = 0;
        chk("reset_outs", {lane_ready, byte_valid, byte_o, byte_last, busy, done}, 0);

        // T1 cycle-exact: lane accepted, bytes 01..08, done next cycle
        start = 1; len = 8; step(); start = 0;
        chk("t1_load", {busy, lane_ready, byte_valid}, 3'b110);
        lane_valid = 1; lane = 64'h0807060504030201; step(); lane_valid = 0;
        byte_ready = 1;
        for (int k = 0; k < 8; k++) begin
            chk("t1_byte", {byte_valid, byte_last, byte_o}, {1'b1, k == 7, 8'(k + 1)});
            step();
        end
        byte_ready = 0;
        chk("t1_done", {done, byte_valid, lane_ready}, 3'b100);
        step();
        chk("t1_idle", {done, busy}, 2'b00);

        // T1 again through the generic runner
        run(8, 8'h01, 10'h3FF, 9, 0);

        // T2: 11 bytes over two lanes, bubble costs one cycle
        lanes[0] = 64'h0706050403020100; lanes[1] = 64'h0F0E0D0C0B0A0908;
        run(11, 8'h00, 10'h3FF, 13, 0);

        // T3: stalls with pattern 1,0,0,1,0,1,1,1,1,1
        lanes[0] = 64'h0807060504030201;
        run(8, 8'h01, 10'b1001011111, 12, 0);

        // T4: zero-length request
        start = 1; len = 0; step(); start = 0;
        chk("t4_done", {done, lane_ready, byte_valid}, 3'b100);
        step();
        chk("t4_idle", {done, busy, lane_ready, byte_valid}, 4'b0000);

        // T5: reset mid-EMIT after three bytes
        start = 1; len = 8; step(); start = 0;
        lane_valid = 1; lane = lanes[0]; step(); lane_valid = 0;
        byte_ready = 1; step(); step(); step();
        chk("t5_byte3", byte_o, 8'h04);
        byte_ready = 0; rst = 1; step(); rst = 0;
        chk("t5_reset_outs", {lane_ready, byte_valid, byte_o, byte_last, busy, done}, 0);
        run(8, 8'h01, 10'h3FF, 9, 0);

        // T6: lane_valid in IDLE ignored, start while busy ignored
        lane_valid = 1; lane = 64'hDEAD; step(); step();
        chk("t6_idle_lane", {lane_ready, busy}, 2'b00);
        lane_valid = 0;
        run(8, 8'h01, 10'h3FF, 9, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
